msx_mem_bus_bridge: RTL
=======================

# msx_mem_bus_bridge

Z80-side memory bus bridge that sits directly upstream of the FM BIOS ROM unit and the other 14-bit-addressed memory units. It synchronizes the asynchronous Z80 strobes into the i_CLK domain and decodes the target page. It then drives the unit's select/address/read strobe, inserts Z80 wait states while the unit is busy, and latches and drives the returned byte onto the Z80 data bus until the cycle ends.

## Interface
- P_PAGE, 2'd1, Z80 16 KB page (address bits [15:14]) decoded for the unit.
- P_TIMEOUT, 8'd63, maximum i_CLK cycles spent waiting on i_MEM_BUSY.
- i_CLK  in  1  system clock; must be ≥ 8× Z80 clock.
- i_RST_n  in  1  reset, synchronous, active-low.
- i_Z80_ADDR16  in  16  Z80 address; sampled only at request start.
- i_Z80_MREQ_n / i_Z80_RD_n / i_Z80_WR_n  in  1 each  asynchronous Z80 strobes.
- i_Z80_DATA8  in  8  Z80 write data.
- i_SLOT_HIT  in  1  slot decoder reports this slot selected for the current page.
- o_Z80_DATA8  out  8  read data to Z80.
- o_Z80_DATA_OE  out  1  drive enable for o_Z80_DATA8.
- o_Z80_WAIT_n  out  1  Z80 WAIT, active-low.
- o_MEM_EN  out  1  unit select.
- o_MEM_ADDR14  out  14  unit address (latched i_Z80_ADDR16[13:0]).
- o_MEM_RD8  out  1  unit read strobe.
- o_MEM_WR8  out  1  unit write strobe, one-cycle pulse.
- o_MEM_WDATA8  out  8  latched write data.
- i_MEM_DATA8  in  8  unit read data; valid only while o_MEM_EN && o_MEM_RD8.
- i_MEM_BUSY  in  1  unit busy.

## Operation
- Each strobe passes through a 2-FF synchronizer; the sync flops reset to 1. "Start" means the synchronized MREQ_n is low, synchronized RD_n or WR_n is low, and the FSM is in IDLE with `armed` set.
- `armed` clears on reset and sets once synchronized MREQ_n is seen high. An access already in progress at reset release is ignored.
- Hit means i_Z80_ADDR16[15:14]==P_PAGE && i_SLOT_HIT, sampled at Start. RD has priority if RD and WR are both low; WR is then ignored.
- FSM states: IDLE, REQ, DATA, HOLD, SKIP.
  - IDLE: on Start with miss, go to SKIP. On Start with hit, latch address and write data, set o_MEM_EN=1, set o_MEM_RD8 (read) or pulse o_MEM_WR8 (write), set o_Z80_WAIT_n=0, go to REQ.
  - REQ: one cycle. o_MEM_WR8 returns to 0. Read goes to DATA; write goes to HOLD.
  - DATA: when i_MEM_BUSY=0, latch i_MEM_DATA8 into o_Z80_DATA8, drop o_MEM_EN and o_MEM_RD8, set o_Z80_DATA_OE=1 and o_Z80_WAIT_n=1, go to HOLD.
  - HOLD: o_Z80_WAIT_n=1. For a read, o_MEM_EN and o_MEM_RD8 are already low; for a write, drop o_MEM_EN. When synchronized MREQ_n is high, clear o_Z80_DATA_OE and go to IDLE.
  - SKIP: no outputs asserted. When synchronized MREQ_n is high, go to IDLE.
- Write data is forwarded to the unit; ROM units ignore it, and the cycle still completes with a wait of 2 cycles.
- Strobe release during REQ or DATA (Z80 aborted) goes straight to IDLE and clears all strobes, wait and OE.

## Timing
- Reset values: o_Z80_DATA8=8'h00, o_Z80_DATA_OE=0, o_Z80_WAIT_n=1, o_MEM_EN=0, o_MEM_ADDR14=0, o_MEM_RD8=0, o_MEM_WR8=0, o_MEM_WDATA8=0.
- Let E0 be the edge at which the synchronized strobes first show Start. o_MEM_EN, o_MEM_RD8 and o_Z80_WAIT_n=0 become valid after E0. This is 2–3 cycles after the raw strobe falls.
- With i_MEM_BUSY=0, data is latched at edge E0+2 and o_Z80_WAIT_n=1 and OE=1 follow after E0+2. Total wait is 2 i_CLK cycles.
- Each extra cycle of i_MEM_BUSY=1 while in DATA adds one cycle.
- o_Z80_DATA_OE falls one cycle after synchronized MREQ_n goes high, which is 3 cycles after the raw rise.
- Back-to-back accesses need one IDLE cycle between them.

## Configuration
- MEM_TIMEOUT_EN defined: an 8-bit counter runs in DATA. If it reaches P_TIMEOUT while busy is still 1, the FSM latches 8'hFF, releases wait, goes to HOLD, and pulses an internal timeout flag.
- MEM_TIMEOUT_EN undefined: no counter; DATA waits indefinitely for busy=0.

## Test plan
- Read 0x4018 with hit and busy=0 (unit returns 8'h41) -> o_MEM_ADDR14=14'h0018, wait low for exactly 2 cycles, o_Z80_DATA8=8'h41 with OE until 3 cycles after MREQ_n rises.
- Read 0x8018 with P_PAGE=1, or read 0x4018 with i_SLOT_HIT=0 -> o_MEM_EN never 1, wait stays 1, OE stays 0.
- Read 0x401F with busy held high 5 cycles -> wait low 7 cycles, data 8'h4C.
- With MEM_TIMEOUT_EN defined, busy stuck at 1 -> wait released after P_TIMEOUT=63 cycles, data 8'hFF.
- Write 0x4000 with data 8'h5A -> one-cycle o_MEM_WR8, o_MEM_WDATA8=8'h5A, OE never 1.
- Reset asserted during DATA while MREQ_n stays low -> all outputs at reset values. No new access is issued until MREQ_n goes high and then low again.

Source files
------------

// File: rtl/msx_mem_bus_bridge.sv
// msx_mem_bus_bridge: Z80 memory-cycle bridge to a 14-bit-addressed memory unit on page P_PAGE
// Ports: i_CLK/i_RST_n (sync, active-low); i_Z80_* asynchronous Z80 strobes, address and write data;
//   i_SLOT_HIT slot select; o_Z80_DATA8/o_Z80_DATA_OE read-data drive; o_Z80_WAIT_n wait request;
//   o_MEM_EN/o_MEM_ADDR14/o_MEM_RD8/o_MEM_WR8/o_MEM_WDATA8 unit request; i_MEM_DATA8/i_MEM_BUSY unit reply.
// Option: define MEM_TIMEOUT_EN to bound the busy wait to P_TIMEOUT cycles (returns 8'hFF on expiry).
module msx_mem_bus_bridge #(
  parameter logic [1:0] P_PAGE    = 2'd1,
  parameter logic [7:0] P_TIMEOUT = 8'd63
) (
  input  logic        i_CLK,
  input  logic        i_RST_n,
  input  logic [15:0] i_Z80_ADDR16,
  input  logic        i_Z80_MREQ_n,
  input  logic        i_Z80_RD_n,
  input  logic        i_Z80_WR_n,
  input  logic [7:0]  i_Z80_DATA8,
  input  logic        i_SLOT_HIT,
  output logic [7:0]  o_Z80_DATA8,
  output logic        o_Z80_DATA_OE,
  output logic        o_Z80_WAIT_n,
  output logic        o_MEM_EN,
  output logic [13:0] o_MEM_ADDR14,
  output logic        o_MEM_RD8,
  output logic        o_MEM_WR8,
  output logic [7:0]  o_MEM_WDATA8,
  input  logic [7:0]  i_MEM_DATA8,
  input  logic        i_MEM_BUSY
);
  localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, DATA = 3'd2, HOLD = 3'd3, SKIP = 3'd4;
  logic [2:0] sync1, sync2, state;
  logic [1:0] vld;
  logic armed, is_rd, start, hit, rel, tmo;
  logic mreq_s, rd_s, wr_s;
  assign {mreq_s, rd_s, wr_s} = sync2;
  assign start = state == IDLE && armed && !mreq_s && (!rd_s || !wr_s);
  assign hit = i_Z80_ADDR16[15:14] == P_PAGE && i_SLOT_HIT;
  assign rel = mreq_s || (rd_s && wr_s);
`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt;
  logic timeout_pulse;
  assign tmo = i_MEM_BUSY && cnt == P_TIMEOUT;
  always_ff @(posedge i_CLK)
    if (!i_RST_n) begin
      cnt <= 8'd0;
      timeout_pulse <= 1'b0;
    end else begin
      cnt <= state == DATA ? cnt + 8'd1 : 8'd0;
      timeout_pulse <= state == DATA && !rel && tmo;
    end
`else
  assign tmo = 1'b0 & |P_TIMEOUT;
`endif
  // vld masks the synchronizer reset value so a cycle already in flight at reset release cannot arm us
  always_ff @(posedge i_CLK)
    if (!i_RST_n) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
      vld <= 2'b00;
      armed <= 1'b0;
      is_rd <= 1'b0;
      state <= IDLE;
      o_Z80_DATA8 <= 8'h00;
      o_Z80_DATA_OE <= 1'b0;
      o_Z80_WAIT_n <= 1'b1;
      o_MEM_EN <= 1'b0;
      o_MEM_ADDR14 <= 14'd0;
      o_MEM_RD8 <= 1'b0;
      o_MEM_WR8 <= 1'b0;
      o_MEM_WDATA8 <= 8'h00;
    end else begin
      sync1 <= {i_Z80_MREQ_n, i_Z80_RD_n, i_Z80_WR_n};
      sync2 <= sync1;
      vld <= {vld[0], 1'b1};
      if (vld[1] && mreq_s) armed <= 1'b1;
      o_MEM_WR8 <= 1'b0;
      case (state)
        IDLE:
          if (start && hit) begin
            state <= REQ;
            is_rd <= !rd_s;
            o_MEM_ADDR14 <= i_Z80_ADDR16[13:0];
            o_MEM_WDATA8 <= i_Z80_DATA8;
            o_MEM_EN <= 1'b1;
            o_MEM_RD8 <= !rd_s;
            o_MEM_WR8 <= rd_s;
            o_Z80_WAIT_n <= 1'b0;
          end else if (start) state <= SKIP;
        REQ, DATA:
          if (rel) begin
            state <= IDLE;
            o_MEM_EN <= 1'b0;
            o_MEM_RD8 <= 1'b0;
            o_Z80_WAIT_n <= 1'b1;
            o_Z80_DATA_OE <= 1'b0;
          end else if (state == REQ) state <= is_rd ? DATA : HOLD;
          else if (!i_MEM_BUSY || tmo) begin
            state <= HOLD;
            o_Z80_DATA8 <= tmo ? 8'hFF : i_MEM_DATA8;
            o_MEM_EN <= 1'b0;
            o_MEM_RD8 <= 1'b0;
            o_Z80_DATA_OE <= 1'b1;
            o_Z80_WAIT_n <= 1'b1;
          end
        HOLD: begin
          o_Z80_WAIT_n <= 1'b1;
          o_MEM_EN <= 1'b0;
          if (mreq_s) begin
            o_Z80_DATA_OE <= 1'b0;
            state <= IDLE;
          end
        end
        SKIP: if (mreq_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
